// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: round-robin share of one SDRAM command port between two masters, with read-return tag FIFO
`timescale 1ns/1ps
module sdram_port_arbiter #(
  parameter int ADDR_W = 22,
  parameter int DATA_W = 16,
  parameter int BE_W   = 2,
  parameter int MAX_RD = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_rd_n,
  input  logic              p0_wr_n,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_data,
  input  logic [BE_W-1:0]   p0_be_n,
  output logic              p0_wait_req,
  output logic              p0_valid,
  input  logic              p1_rd_n,
  input  logic              p1_wr_n,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_data,
  input  logic [BE_W-1:0]   p1_be_n,
  output logic              p1_wait_req,
  output logic              p1_valid,
  output logic [DATA_W-1:0] p_rdata,
  output logic [ADDR_W-1:0] az_addr,
  output logic [DATA_W-1:0] az_data,
  output logic [BE_W-1:0]   az_be_n,
  output logic              az_rd_n,
  output logic              az_wr_n,
  input  logic [DATA_W-1:0] za_data,
  input  logic              za_valid,
  input  logic              za_waitrequest,
  output logic              o_error
);
  localparam int PW = $clog2(MAX_RD);
  localparam logic [PW:0] FULL = (PW+1)'(MAX_RD);
  typedef enum logic {ARB, GRANT} state_t;
  state_t state_q, state_d;
  logic owner_q, owner_d, last_q, last_d, err_q, err_d;
  logic [MAX_RD-1:0] fifo_q, fifo_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW:0] cnt_q, cnt_d;
  logic rd0, rd1, elig0, elig1, room, grant, o_rd, o_wr, accept, push, pop, head;
  assign rd0 = ~p0_rd_n;
  assign rd1 = ~p1_rd_n;
  assign room = cnt_q < FULL;
  assign elig0 = (rd0 & room) | (~p0_wr_n & ~rd0);
  assign elig1 = (rd1 & room) | (~p1_wr_n & ~rd1);
  assign grant = state_q == GRANT;
  // a port driving both strobes low is issued as a read only
  assign o_rd = owner_q ? rd1 : rd0;
  assign o_wr = owner_q ? (~p1_wr_n & p1_rd_n) : (~p0_wr_n & p0_rd_n);
  assign accept = grant & (o_rd | o_wr) & ~za_waitrequest;
  assign push = accept & o_rd;
  assign pop = za_valid & (cnt_q != '0);
  assign head = fifo_q[rd_ptr_q];
  assign az_rd_n = ~(grant & o_rd);
  assign az_wr_n = ~(grant & o_wr);
  assign az_addr = grant ? (owner_q ? p1_addr : p0_addr) : '0;
  assign az_data = grant ? (owner_q ? p1_data : p0_data) : '0;
  assign az_be_n = grant ? (owner_q ? p1_be_n : p0_be_n) : '0;
  assign p0_wait_req = ~(grant & ~owner_q & ~za_waitrequest);
  assign p1_wait_req = ~(grant & owner_q & ~za_waitrequest);
  assign p0_valid = pop & ~head;
  assign p1_valid = pop & head;
  assign p_rdata = za_data;
  assign o_error = err_q;
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d = last_q;
    fifo_d = fifo_q;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    err_d = err_q | (rd0 & ~p0_wr_n) | (rd1 & ~p1_wr_n) | (za_valid & (cnt_q == '0));
    if (push) fifo_d[wr_ptr_q] = owner_q;
    if (state_q == ARB) begin
      state_d = (elig0 | elig1) ? GRANT : ARB;
      owner_d = (elig0 & elig1) ? ~last_q : (elig1 | (~elig0 & owner_q));
    end else if (accept) begin
      state_d = ARB;
      last_d = owner_q;
    end else if (~(o_rd | o_wr)) begin
      state_d = ARB;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB;
      owner_q <= 1'b0;
      last_q <= 1'b1;
      fifo_q <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q <= last_d;
      fifo_q <= fifo_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: directed stimulus checked every cycle against a queue-based model plus literal expectations
`timescale 1ns/1ps
module tb_sdram_port_arbiter;
  localparam int AW = 22, DW = 16, BW = 2, MR = 8;
  logic clk = 1'b0, reset = 1'b1;
  logic [1:0] rd_n = 2'b11, wr_n = 2'b11;
  logic [AW-1:0] addr [2];
  logic [DW-1:0] data [2];
  logic [BW-1:0] be_n [2];
  logic [DW-1:0] za_data = '0;
  logic za_valid = 1'b0, za_waitrequest = 1'b0;
  logic p0_wait_req, p1_wait_req, p0_valid, p1_valid, az_rd_n, az_wr_n, o_error;
  logic [DW-1:0] p_rdata, az_data;
  logic [AW-1:0] az_addr;
  logic [BW-1:0] az_be_n;
  logic [1:0] wq;
  assign wq = {p1_wait_req, p0_wait_req};

  sdram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW), .MAX_RD(MR)) dut (
    .clk(clk), .reset(reset),
    .p0_rd_n(rd_n[0]), .p0_wr_n(wr_n[0]), .p0_addr(addr[0]), .p0_data(data[0]), .p0_be_n(be_n[0]),
    .p0_wait_req(p0_wait_req), .p0_valid(p0_valid),
    .p1_rd_n(rd_n[1]), .p1_wr_n(wr_n[1]), .p1_addr(addr[1]), .p1_data(data[1]), .p1_be_n(be_n[1]),
    .p1_wait_req(p1_wait_req), .p1_valid(p1_valid),
    .p_rdata(p_rdata), .az_addr(az_addr), .az_data(az_data), .az_be_n(az_be_n),
    .az_rd_n(az_rd_n), .az_wr_n(az_wr_n), .za_data(za_data), .za_valid(za_valid),
    .za_waitrequest(za_waitrequest), .o_error(o_error)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, acc_cnt = 0;
  bit chk_en = 1'b0;
  bit acc_log[$];
  bit v_log[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: a granted slot (or none), the round-robin pointer and a queue of read tags
  bit m_grant = 1'b0, m_own = 1'b0, m_last = 1'b1, m_err = 1'b0;
  bit m_tags[$];
  bit [1:0] rq, rdq, el, e_wq, e_v;
  bit e_rd, e_wr, room;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  logic [BW-1:0] e_be;

  always @(negedge clk) begin
    rq = ~rd_n | ~wr_n;
    rdq = ~rd_n;
    e_rd = m_grant && rdq[m_own];
    e_wr = m_grant && !wr_n[m_own] && !rdq[m_own];
    e_addr = m_grant ? addr[m_own] : '0;
    e_data = m_grant ? data[m_own] : '0;
    e_be = m_grant ? be_n[m_own] : '0;
    e_wq = !m_grant ? 2'b11 : (m_own ? {za_waitrequest, 1'b1} : {1'b1, za_waitrequest});
    e_v = 2'b00;
    if (za_valid && m_tags.size() > 0) e_v[m_tags[0]] = 1'b1;
    if ((!az_rd_n || !az_wr_n) && !za_waitrequest) acc_cnt++;
    if (p0_valid) v_log.push_back(1'b0);
    if (p1_valid) v_log.push_back(1'b1);
    if (chk_en) begin
      chk("az_rd_n", 32'(az_rd_n), 32'(!e_rd));
      chk("az_wr_n", 32'(az_wr_n), 32'(!e_wr));
      chk("az_addr", 32'(az_addr), 32'(e_addr));
      chk("az_data", 32'(az_data), 32'(e_data));
      chk("az_be_n", 32'(az_be_n), 32'(e_be));
      chk("wait_req", 32'(wq), 32'(e_wq));
      chk("valid", 32'({p1_valid, p0_valid}), 32'(e_v));
      chk("p_rdata", 32'(p_rdata), 32'(za_data));
      chk("o_error", 32'(o_error), 32'(m_err));
    end
    if (reset) begin
      m_grant = 1'b0;
      m_last = 1'b1;
      m_err = 1'b0;
      m_tags.delete();
    end else begin
      room = m_tags.size() < MR;
      if ((rdq[0] && !wr_n[0]) || (rdq[1] && !wr_n[1]) || (za_valid && m_tags.size() == 0)) m_err = 1'b1;
      if (za_valid && m_tags.size() > 0) void'(m_tags.pop_front());
      if (!m_grant) begin
        el[0] = rq[0] && (!rdq[0] || room);
        el[1] = rq[1] && (!rdq[1] || room);
        if (el != 2'b00) begin
          m_grant = 1'b1;
          m_own = (el == 2'b11) ? !m_last : el[1];
        end
      end else if ((e_rd || e_wr) && !za_waitrequest) begin
        m_last = m_own;
        if (e_rd) m_tags.push_back(m_own);
        m_grant = 1'b0;
      end else if (!(e_rd || e_wr)) begin
        m_grant = 1'b0;
      end
    end
  end

  task automatic master(input int p, input bit rd, input int n, input logic [AW-1:0] a0);
    for (int k = 0; k < n; k++) begin
      int t;
      t = 0;
      rd_n[p] = !rd;
      wr_n[p] = rd;
      addr[p] = a0 + AW'(k);
      data[p] = DW'(32'h1000 + k + p * 256);
      be_n[p] = BW'(k);
      #1;
      while (wq[p] !== 1'b0 && t < 100) begin
        tick();
        #1;
        t++;
      end
      chk("master_grant", 32'(wq[p]), 32'(0));
      tick();
      acc_log.push_back(p[0]);
    end
    rd_n[p] = 1'b1;
    wr_n[p] = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      addr[i] = '0;
      data[i] = '0;
      be_n[i] = '0;
    end
    repeat (2) tick();
    reset = 1'b0;
    chk_en = 1'b1;
    chk("reset_o_error", 32'(o_error), 32'(0));
    chk("reset_wait_req", 32'(wq), 32'(2'b11));
    // single read, data returns 3 cycles after accept
    rd_n[0] = 1'b0;
    addr[0] = 22'h000123;
    #1;
    chk("single_arb_rd_n", 32'(az_rd_n), 32'(1));
    tick();
    chk("single_grant_rd_n", 32'(az_rd_n), 32'(0));
    chk("single_grant_addr", 32'(az_addr), 32'h123);
    chk("single_grant_wait", 32'(p0_wait_req), 32'(0));
    tick();
    rd_n[0] = 1'b1;
    repeat (3) tick();
    za_valid = 1'b1;
    za_data = 16'hBEEF;
    #1;
    chk("single_p0_valid", 32'(p0_valid), 32'(1));
    chk("single_p1_valid", 32'(p1_valid), 32'(0));
    chk("single_rdata", 32'(p_rdata), 32'hBEEF);
    tick();
    za_valid = 1'b0;
    // contention: both ports stream writes, grants must alternate starting at p0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    acc_log.delete();
    fork
      master(0, 1'b0, 4, 22'h100);
      master(1, 1'b0, 4, 22'h200);
    join
    chk("contend_count", 32'(acc_log.size()), 32'(8));
    for (int k = 0; k < acc_log.size(); k++) chk("contend_order", 32'(acc_log[k]), 32'(k % 2));
    // stall: p1 write held through 5 cycles of waitrequest
    tick();
    acc_cnt = 0;
    za_waitrequest = 1'b1;
    wr_n[1] = 1'b0;
    addr[1] = 22'h2AAAA;
    data[1] = 16'h5A5A;
    be_n[1] = 2'b01;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("stall_addr", 32'(az_addr), 32'h2AAAA);
      chk("stall_data", 32'(az_data), 32'h5A5A);
      chk("stall_wr_n", 32'(az_wr_n), 32'(0));
      chk("stall_wait", 32'(wq), 32'(2'b11));
      tick();
    end
    za_waitrequest = 1'b0;
    #1;
    chk("stall_release_wait", 32'(wq), 32'(2'b01));
    tick();
    wr_n[1] = 1'b1;
    tick();
    chk("stall_accepts", 32'(acc_cnt), 32'(1));
    // ordering, including one push and pop in the same cycle
    v_log.delete();
    fork
      begin
        master(0, 1'b1, 1, 22'h300);
        master(1, 1'b1, 2, 22'h310);
        master(0, 1'b1, 1, 22'h320);
      end
      begin
        repeat (7) tick();
        za_valid = 1'b1;
        za_data = 16'hC0DE;
        repeat (4) tick();
        za_valid = 1'b0;
      end
    join
    chk("order_count", 32'(v_log.size()), 32'(4));
    for (int k = 0; k < v_log.size() && k < 4; k++)
      chk("order_port", 32'(v_log[k]), 32'((k == 1 || k == 2) ? 1 : 0));
    // full tag FIFO: ninth read held while a write from p1 still proceeds
    tick();
    master(0, 1'b1, 8, 22'h400);
    rd_n[0] = 1'b0;
    addr[0] = 22'h4FF;
    fork
      master(1, 1'b0, 1, 22'h500);
      begin
        for (int i = 0; i < 4; i++) begin
          #1;
          chk("full_hold_wait", 32'(wq[0]), 32'(1));
          chk("full_hold_rd_n", 32'(az_rd_n), 32'(1));
          tick();
        end
      end
    join
    za_valid = 1'b1;
    za_data = 16'h0F0F;
    tick();
    za_valid = 1'b0;
    begin
      int t;
      t = 0;
      #1;
      while (wq[0] !== 1'b0 && t < 10) begin
        tick();
        #1;
        t++;
      end
      chk("full_release", 32'(wq[0]), 32'(0));
    end
    tick();
    rd_n[0] = 1'b1;
    za_valid = 1'b1;
    repeat (8) tick();
    za_valid = 1'b0;
    // reset while granted with 3 reads outstanding
    master(0, 1'b1, 3, 22'h600);
    rd_n[1] = 1'b0;
    addr[1] = 22'h611;
    za_waitrequest = 1'b1;
    tick();
    tick();
    chk("rst_pre_rd_n", 32'(az_rd_n), 32'(0));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rd_n[1] = 1'b1;
    za_waitrequest = 1'b0;
    #1;
    chk("rst_rd_n", 32'(az_rd_n), 32'(1));
    chk("rst_wr_n", 32'(az_wr_n), 32'(1));
    chk("rst_wait", 32'(wq), 32'(2'b11));
    za_valid = 1'b1;
    #1;
    chk("rst_late_valid", 32'({p1_valid, p0_valid}), 32'(0));
    tick();
    za_valid = 1'b0;
    #1;
    chk("rst_late_error", 32'(o_error), 32'(1));
    // both strobes low on one port: issued as a read and flagged
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("both_pre_error", 32'(o_error), 32'(0));
    rd_n[0] = 1'b0;
    wr_n[0] = 1'b0;
    addr[0] = 22'h700;
    tick();
    chk("both_rd_n", 32'(az_rd_n), 32'(0));
    chk("both_wr_n", 32'(az_wr_n), 32'(1));
    chk("both_error", 32'(o_error), 32'(1));
    tick();
    rd_n[0] = 1'b1;
    wr_n[0] = 1'b1;
    za_valid = 1'b1;
    #1;
    chk("both_return", 32'(p0_valid), 32'(1));
    tick();
    za_valid = 1'b0;
    repeat (2) tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Two-port round-robin arbiter that shares one SDRAM controller command port (az_*/za_* handshake) between two masters, e.g. the init reader/writer and a second client.
- Registers each grant and holds the command stable through controller waitrequest.
- Tracks outstanding reads in a tag FIFO so pipelined za_valid read data goes back to the port that issued the read.

Parameters:
- ADDR_W, 22, word address width
- DATA_W, 16, data width
- BE_W, 2, byte-enable width (active-low)
- MAX_RD, 8, max outstanding reads, i.e. tag FIFO depth; power of two, ≥2

Ports:
- clk  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-high
- p0_rd_n, p1_rd_n  in  1  read request, active-low
- p0_wr_n, p1_wr_n  in  1  write request, active-low
- p0_addr, p1_addr  in  ADDR_W  address
- p0_data, p1_data  in  DATA_W  write data
- p0_be_n, p1_be_n  in  BE_W  byte mask
- p0_wait_req, p1_wait_req  out  1  port must hold its command while high
- p0_valid, p1_valid  out  1  read data valid for that port
- p_rdata  out  DATA_W  read data, shared by both ports (=za_data)
- az_addr  out  ADDR_W  controller address
- az_data  out  DATA_W  controller write data
- az_be_n  out  BE_W  controller byte mask
- az_rd_n, az_wr_n  out  1  controller read/write strobes, active-low
- za_data  in  DATA_W  controller read data
- za_valid  in  1  controller read data valid
- za_waitrequest  in  1  controller stall
- o_error  out  1  sticky protocol error

Behaviour:
- States: ARB, GRANT. Registers: owner (1b), last (1b), tag FIFO (MAX_RD x 1b, with count).
- Reset values (reset high at any clock edge):
  - state=ARB, last=1 (port 0 wins first), FIFO emptied, o_error=0.
  - Everything in flight is discarded; late za_valid after reset is ignored.
- Request rules:
  - req_x = ~px_rd_n | ~px_wr_n.
  - Eligibility: a read request is eligible only if count<MAX_RD. A write request is always eligible.
  - If both rd_n and wr_n are low on one port: treated as a read and o_error set.
- ARB state:
  - Outputs: az_rd_n=az_wr_n=1, az_addr/az_data/az_be_n=0, p0_wait_req=p1_wait_req=1.
  - If exactly one port is eligible: owner<=that port, go to GRANT.
  - If both are eligible: owner<=~last, go to GRANT.
  - If neither: stay in ARB.
- GRANT state:
  - az_* = owner's command, combinationally muxed from that port's inputs.
  - p<owner>_wait_req = za_waitrequest; the other port's wait_req=1.
  - Accept condition: az strobe active & ~za_waitrequest.
  - On accept: last<=owner; if read, push owner into FIFO; go to ARB.
  - Owner drops its request without being accepted: go to ARB, no push (protocol violation tolerated, not flagged).
- Throughput: one ARB bubble per transaction, so ≥2 cycles per command. Latency from request to earliest az strobe is 1 cycle.
- Read return:
  - When za_valid=1: pop FIFO head h; ph_valid=1 in the same cycle (combinational); the other port's valid=0.
  - p_rdata = za_data at all times.
- Simultaneous push and pop: count unchanged; FIFO ordering preserved.
- Full FIFO: a new read is not granted until a pop frees an entry. A read that was granted before the FIFO became full still completes, because the count check is done in ARB.
- za_valid with count==0: o_error<=1, no pop, both port valid=0.
- o_error clears only on reset.

Test Plan:
- Single read: p0 read addr 0x000123, za_waitrequest=0, za_valid 3 cycles after accept with data 0xBEEF -> az_rd_n low 1 cycle after request; p0_valid=1 with p_rdata=0xBEEF; p1_valid stays 0.
- Contention: p0 and p1 both hold writes continuously for 8 transactions, za_waitrequest=0 -> grants alternate p0,p1,p0,...; first grant goes to p0; each port gets 4 accepts.
- Stall: p1 write, za_waitrequest high for 5 cycles -> az_addr/az_data/az_wr_n stable for all 5 cycles; p1_wait_req high; p0_wait_req=1; exactly one accept.
- Ordering: reads issued p0,p1,p1,p0 with za_valid delayed -> valids return in order p0,p1,p1,p0; also cover a push and pop in the same cycle.
- Full FIFO with MAX_RD=8: 8 reads outstanding, no za_valid yet -> 9th read is held (wait_req=1, az_rd_n=1); a concurrent write from the other port is still granted; after one za_valid the 9th read is granted.
- Reset and errors:
  - reset pulse while in GRANT with 3 reads outstanding -> next cycle az strobes high, both wait_req=1, FIFO empty.
  - za_valid afterwards -> o_error=1, no port valid.
  - both rd_n and wr_n low on one port -> treated as a read; o_error=1.
